pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// -----------------------------------------------------------------------------
// pipeline_controller
//   Stall/flush sequencer for a classic 5-stage pipeline. Resolves memory
//   stalls, taken-branch flushes and data-hazard bubbles, one action per cycle
//   (memory > branch > hazard). Control outputs are combinational from the
//   current state, the registered counters and the current inputs.
//
// Parameters
//   BRANCH_PENALTY : cycles flush is asserted per taken branch (1..7)
//   MEM_TIMEOUT    : maximum MEM_WAIT cycles before the access is aborted (1..255)
//
// Ports
//   clk             : clock, all state changes on the rising edge
//   rst             : synchronous active-low reset
//   hazard_detected : data hazard on the ID-stage instruction
//   branch_taken    : taken branch resolved in EXE
//   mem_access      : MEM-stage instruction is a load or store
//   mem_ready       : memory completes the current access this cycle
//   clr_count       : synchronous clear of stall_count
//   mem_start       : single-cycle access request to memory
//   freeze_front    : hold PC and IF/ID
//   freeze_back     : hold ID/EXE, EXE/MEM and MEM/WB
//   bubble          : zero the control fields written into ID/EXE
//   flush           : clear IF/ID and ID/EXE
//   mem_timeout     : sticky memory-timeout error
//   stall_count     : saturating count of cycles with freeze_front high
//   state           : current state encoding (RUN/MEM_WAIT/FLUSH)
// -----------------------------------------------------------------------------
module pipeline_controller #(
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_detected,
  input  logic        branch_taken,
  input  logic        mem_access,
  input  logic        mem_ready,
  input  logic        clr_count,
  output logic        mem_start,
  output logic        freeze_front,
  output logic        freeze_back,
  output logic        bubble,
  output logic        flush,
  output logic        mem_timeout,
  output logic [15:0] stall_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_e;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);
  localparam logic [2:0] PENALTY_M1  = 3'(BRANCH_PENALTY - 1);

  state_e      r_state;
  logic [7:0]  r_wait_cnt;
  logic [2:0]  r_flush_cnt;
  logic [15:0] r_stall_count;
  logic        r_mem_timeout;

  state_e      w_state_nxt;
  logic [7:0]  w_wait_nxt;
  logic [2:0]  w_flush_nxt;
  logic        w_timeout_set;
  logic        w_wait_expired;

  assign w_wait_expired = (r_wait_cnt == TIMEOUT_VAL);

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_flush_cnt   <= '0;
      r_stall_count <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_flush_cnt   <= w_flush_nxt;
      r_mem_timeout <= r_mem_timeout | w_timeout_set;
      // Clear has priority over the increment in the same cycle.
      if (clr_count)
        r_stall_count <= '0;
      else if (freeze_front && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter update
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_flush_nxt   = r_flush_cnt;
    w_timeout_set = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (mem_access) begin
          // A same-cycle mem_ready completes the access without stalling.
          if (!mem_ready) begin
            w_state_nxt = ST_MEM_WAIT;
            w_wait_nxt  = 8'd1;
          end
        end else if (branch_taken) begin
          // The RUN cycle itself is the first flush cycle.
          if (BRANCH_PENALTY > 1) begin
            w_state_nxt = ST_FLUSH;
            w_flush_nxt = PENALTY_M1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
        end else if (w_wait_expired) begin
          w_state_nxt   = ST_RUN;
          w_wait_nxt    = '0;
          w_timeout_set = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + 8'd1;
        end
      end
      ST_FLUSH: begin
        // Branches and hazards are ignored here; the flushed stages hold
        // nothing worth acting on.
        if (r_flush_cnt <= 3'd1) begin
          w_state_nxt = ST_RUN;
          w_flush_nxt = '0;
        end else begin
          w_flush_nxt = r_flush_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = '0;
        w_flush_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control outputs (zero latency, forced low while reset is asserted)
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_start    = 1'b0;
    freeze_front = 1'b0;
    freeze_back  = 1'b0;
    bubble       = 1'b0;
    flush        = 1'b0;
    if (rst) begin
      unique case (r_state)
        ST_RUN: begin
          if (mem_access) begin
            mem_start    = 1'b1;
            freeze_front = !mem_ready;
            freeze_back  = !mem_ready;
          end else if (branch_taken) begin
            flush = 1'b1;
          end else if (hazard_detected) begin
            freeze_front = 1'b1;
            bubble       = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // On timeout the pipeline is released in the same cycle.
          freeze_front = !mem_ready && !w_wait_expired;
          freeze_back  = !mem_ready && !w_wait_expired;
        end
        ST_FLUSH: begin
          flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign stall_count = r_stall_count;
  assign state       = r_state;

endmodule
